// File: rtl/rv_pkg.sv
// Shared definitions for the rv32i decode stage: opcodes, ALU op codes,
// immediate formats and the registered decode payload.
package rv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_SUB    = 5'h01;
    localparam logic [4:0] OP_XOR    = 5'h02;
    localparam logic [4:0] OP_OR     = 5'h03;
    localparam logic [4:0] OP_AND    = 5'h04;
    localparam logic [4:0] OP_SLL    = 5'h05;
    localparam logic [4:0] OP_SRL    = 5'h06;
    localparam logic [4:0] OP_SRA    = 5'h07;
    localparam logic [4:0] OP_SLT    = 5'h08;
    localparam logic [4:0] OP_SLTU   = 5'h09;
    localparam logic [4:0] OP_JAL    = 5'h0A;
    localparam logic [4:0] OP_LUI    = 5'h0B;
    localparam logic [4:0] OP_AUIPC  = 5'h0C;
    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_ECALL  = 5'h1C;
    localparam logic [4:0] OP_EBREAK = 5'h1D;
    localparam logic [4:0] OP_INV    = 5'h1F;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
    } dec_bundle_t;

    localparam dec_bundle_t DEC_RESET = '{op: OP_INV, default: '0};

    // Base integer op for a funct3; alt selects sub/sra on the shared encodings.
    function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_op = alt ? OP_SUB : OP_ADD;
            3'd1:    alu_op = OP_SLL;
            3'd2:    alu_op = OP_SLT;
            3'd3:    alu_op = OP_SLTU;
            3'd4:    alu_op = OP_XOR;
            3'd5:    alu_op = alt ? OP_SRA : OP_SRL;
            3'd6:    alu_op = OP_OR;
            default: alu_op = OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational rv32i instruction decoder producing one decode bundle
// (pc left at zero; the stage inserts it).
module rv_decode_comb
    import rv_pkg::*;
#(
    parameter bit EN_M   = 1'b0,
    parameter bit STRICT = 1'b1
) (
    input  logic [31:0]  instr,
    output dec_bundle_t  dec
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       alt_ok;
    imm_fmt_t   fmt;
    logic       bad;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign alt_ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));

    always_comb begin
        dec = '0;
        fmt = FMT_I;
        bad = 1'b0;
        case (opcode)
            OPC_OP: begin
                fmt = FMT_R;
                if (f7 == 7'h01) begin
                    bad    = !EN_M;
                    dec.op = OP_MUL | {2'b00, f3};
                end else begin
                    bad    = STRICT && !alt_ok;
                    dec.op = alu_op(f3, instr[30] && (f3 == 3'd0 || f3 == 3'd5));
                end
            end
            OPC_OP_IMM: begin
                // Only shifts carry funct7; addi etc. use those bits as immediate.
                if (f3 == 3'd1 || f3 == 3'd5)
                    bad = STRICT && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5));
                dec.op = alu_op(f3, instr[30] && f3 == 3'd5);
            end
            OPC_LOAD: begin
                bad         = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
                dec.op      = OP_ADD;
                dec.is_load = 1'b1;
            end
            OPC_STORE: begin
                fmt          = FMT_S;
                bad          = (f3 > 3'd2);
                dec.op       = OP_ADD;
                dec.is_store = 1'b1;
            end
            OPC_BRANCH: begin
                fmt           = FMT_B;
                bad           = (f3 == 3'd2) || (f3 == 3'd3);
                dec.op        = OP_SUB;
                dec.is_branch = 1'b1;
            end
            OPC_JAL: begin
                fmt         = FMT_J;
                dec.op      = OP_JAL;
                dec.is_jump = 1'b1;
            end
            OPC_JALR: begin
                dec.op      = OP_ADD;
                dec.is_jump = 1'b1;
            end
            OPC_LUI: begin
                fmt    = FMT_U;
                dec.op = OP_LUI;
            end
            OPC_AUIPC: begin
                fmt    = FMT_U;
                dec.op = OP_AUIPC;
            end
            OPC_SYSTEM: dec.op = instr[20] ? OP_EBREAK : OP_ECALL;
            default:    bad = 1'b1;
        endcase

        case (fmt)
            FMT_I:   dec.imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   dec.imm = {instr[31:12], 12'b0};
            FMT_J:   dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: dec.imm = '0;
        endcase

        dec.rs1 = (fmt == FMT_U || fmt == FMT_J) ? 5'd0 : instr[19:15];
        dec.rs2 = (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B) ? instr[24:20] : 5'd0;
        dec.rd  = (fmt == FMT_S || fmt == FMT_B) ? 5'd0 : instr[11:7];

        if (bad) begin
            dec         = '0;
            dec.op      = OP_INV;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage: combinational decoder feeding a two-entry skid
// buffer (main register drives outputs, skid register absorbs one overflow).
module rv_decode_stage
    import rv_pkg::*;
#(
    parameter bit EN_M   = 1'b0,
    parameter bit STRICT = 1'b1,
    parameter int OP_W   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [31:0]     in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_op,
    output logic [31:0]     out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [31:0]     out_pc,
    output logic            out_is_load,
    output logic            out_is_store,
    output logic            out_is_branch,
    output logic            out_is_jump,
    output logic            out_illegal
);

    dec_bundle_t dec;
    dec_bundle_t new_entry;
    dec_bundle_t m_q, s_q;
    logic        m_valid, s_valid;
    logic        accept, drain;

    rv_decode_comb #(.EN_M(EN_M), .STRICT(STRICT)) u_comb (
        .instr (in_instr),
        .dec   (dec)
    );

    always_comb begin
        new_entry    = dec;
        new_entry.pc = in_pc;
    end

    assign accept = in_valid && !s_valid;
    assign drain  = m_valid && out_ready;

    // in_ready comes straight off the skid flop, so it never depends on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_q     <= DEC_RESET;
            s_q     <= DEC_RESET;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (drain) begin
            if (s_valid) begin
                m_q     <= s_q;
                s_valid <= 1'b0;
            end else if (accept) begin
                m_q <= new_entry;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            if (m_valid) begin
                s_q     <= new_entry;
                s_valid <= 1'b1;
            end else begin
                m_q     <= new_entry;
                m_valid <= 1'b1;
            end
        end
    end

    assign in_ready      = !s_valid;
    assign out_valid     = m_valid;
    assign out_op        = OP_W'(m_q.op);
    assign out_imm       = m_q.imm;
    assign out_rs1       = m_q.rs1;
    assign out_rs2       = m_q.rs2;
    assign out_rd        = m_q.rd;
    assign out_pc        = m_q.pc;
    assign out_is_load   = m_q.is_load;
    assign out_is_store  = m_q.is_store;
    assign out_is_branch = m_q.is_branch;
    assign out_is_jump   = m_q.is_jump;
    assign out_illegal   = m_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: decode vectors, backpressure ordering,
// flush and reset. A second instance decodes with the M extension enabled.
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready, out_valid;
    logic [4:0]  out_op;
    logic [31:0] out_imm, out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal;

    logic        in_ready_m, out_valid_m;
    logic [5:0]  out_op_m;
    logic [31:0] out_imm_m, out_pc_m;
    logic [4:0]  out_rs1_m, out_rs2_m, out_rd_m;
    logic        out_is_load_m, out_is_store_m, out_is_branch_m, out_is_jump_m, out_illegal_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_pc(out_pc),
        .out_is_load(out_is_load), .out_is_store(out_is_store), .out_is_branch(out_is_branch),
        .out_is_jump(out_is_jump), .out_illegal(out_illegal)
    );

    rv_decode_stage #(.EN_M(1'b1), .OP_W(6)) dut_m (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_m), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_op(out_op_m), .out_imm(out_imm_m),
        .out_rs1(out_rs1_m), .out_rs2(out_rs2_m), .out_rd(out_rd_m), .out_pc(out_pc_m),
        .out_is_load(out_is_load_m), .out_is_store(out_is_store_m), .out_is_branch(out_is_branch_m),
        .out_is_jump(out_is_jump_m), .out_illegal(out_illegal_m)
    );

    // flags packed as {load, store, branch, jump, illegal}
    wire [4:0] flags = {out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_dec(input string tag, input logic [4:0] op, input logic [31:0] imm,
                              input logic [4:0] fl);
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " op"}, 32'(out_op), 32'(op));
        check({tag, " imm"}, out_imm, imm);
        check({tag, " flags"}, 32'(flags), 32'(fl));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst op", 32'(out_op), 32'h1F);
        check("rst imm", out_imm, 32'd0);
        check("rst flags", 32'(flags), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        issue(32'h002081B3, 32'h0000_1000);
        expect_dec("add", 5'h00, 32'd0, 5'b00000);
        check("add rs1", 32'(out_rs1), 32'd1);
        check("add rs2", 32'(out_rs2), 32'd2);
        check("add rd", 32'(out_rd), 32'd3);
        check("add pc", out_pc, 32'h0000_1000);

        issue(32'h4032D293, 32'h0000_1004);
        expect_dec("srai", 5'h07, 32'h0000_0403, 5'b00000);
        check("srai rd", 32'(out_rd), 32'd5);

        issue(32'h6032D293, 32'h0000_1008);
        expect_dec("srai bad f7", 5'h1F, 32'd0, 5'b00001);

        issue(32'hFE000EE3, 32'h0000_100C);
        expect_dec("beq", 5'h01, 32'hFFFF_FFFC, 5'b00100);

        issue(32'h023100B3, 32'h0000_1010);
        expect_dec("mul no M", 5'h1F, 32'd0, 5'b00001);
        check("mul M op", 32'(out_op_m), 32'h10);
        check("mul M illegal", 32'(out_illegal_m), 32'd0);
        check("mul M rd", 32'(out_rd_m), 32'd1);

        issue(32'hFF812083, 32'h0000_1014);
        expect_dec("lw", 5'h00, 32'hFFFF_FFF8, 5'b10000);
        check("lw rs1", 32'(out_rs1), 32'd2);

        issue(32'hFF813083, 32'h0000_1018);
        expect_dec("load bad f3", 5'h1F, 32'd0, 5'b00001);

        issue(32'h00532623, 32'h0000_101C);
        expect_dec("sw", 5'h00, 32'd12, 5'b01000);
        check("sw rs2", 32'(out_rs2), 32'd5);

        issue(32'h008000EF, 32'h0000_1020);
        expect_dec("jal", 5'h0A, 32'd8, 5'b00010);

        issue(32'h12345037, 32'h0000_1024);
        expect_dec("lui", 5'h0B, 32'h1234_5000, 5'b00000);

        issue(32'h0000007F, 32'h0000_1028);
        expect_dec("bad opcode", 5'h1F, 32'd0, 5'b00001);

        @(posedge clk); #1;
        check("idle out_valid", 32'(out_valid), 32'd0);

        // Backpressure: A, B, C back to back while execute stalls.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h200;
        @(posedge clk); #1;
        check("bp A held", 32'(out_op), 32'h00);
        check("bp ready after A", 32'(in_ready), 32'd1);
        in_instr = 32'h402081B3; in_pc = 32'h204;
        @(posedge clk); #1;
        check("bp ready after B", 32'(in_ready), 32'd0);
        in_instr = 32'h0020C1B3; in_pc = 32'h208;
        @(posedge clk); #1;
        check("bp stall op", 32'(out_op), 32'h00);
        check("bp stall pc", out_pc, 32'h200);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp B op", 32'(out_op), 32'h01);
        check("bp B pc", out_pc, 32'h204);
        check("bp ready reopen", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp C op", 32'(out_op), 32'h02);
        check("bp C pc", out_pc, 32'h208);
        @(posedge clk); #1;
        check("bp drained", 32'(out_valid), 32'd0);

        // Flush with both entries occupied.
        out_ready = 1'b0;
        issue(32'h002081B3, 32'h300);
        issue(32'h402081B3, 32'h304);
        check("fl full", 32'(in_ready), 32'd0);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0020C1B3;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("fl out_valid", 32'(out_valid), 32'd0);
        check("fl in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        issue(32'h00000073, 32'h400);
        expect_dec("ecall", 5'h1C, 32'd0, 5'b00000);
        issue(32'h00100073, 32'h404);
        expect_dec("ebreak", 5'h1D, 32'd1, 5'b00000);

        // Reset while stalled with both entries full.
        out_ready = 1'b0;
        issue(32'h002081B3, 32'h500);
        issue(32'h402081B3, 32'h504);
        rst = 1'b1;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst in_ready", 32'(in_ready), 32'd1);
        check("mid rst op", 32'(out_op), 32'h1F);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
